// File: rtl/data_fix_ctrl.sv
// data_fix_ctrl: frame gate, FIFO reset sequencer and guard window ahead of the 128->64 width converter.
// Define DATA_FIX_CTRL_DROP_CNT_EN to build the saturating dropped-frame counter; otherwise ov_drop_cnt is 0.
module data_fix_ctrl #(
    parameter int DATA_WD_128   = 128,
    parameter int RST_PULSE_LEN = 4,
    parameter int GUARD_CYCLES  = 8,
    parameter int CNT_WD        = 16
) (
    input  logic                   clk_pix,
    input  logic                   reset_pix,
    input  logic                   i_fval,
    input  logic                   i_data_valid,
    input  logic [DATA_WD_128-1:0] iv_data,
    input  logic                   i_acquisition_start,
    input  logic                   i_stream_enable,
    input  logic                   i_encrypt_state,
    output logic                   o_fifo_reset,
    output logic                   o_fval,
    output logic                   o_data_valid,
    output logic [DATA_WD_128-1:0] ov_data,
    output logic [CNT_WD-1:0]      ov_frame_cnt,
    output logic [CNT_WD-1:0]      ov_drop_cnt,
    output logic                   o_busy
);
    localparam int TMAX = RST_PULSE_LEN > GUARD_CYCLES ? RST_PULSE_LEN : GUARD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, RST, GUARD, PASS, DROP} state_t;

    state_t        state;
    logic          fval_d;
    logic          abort;
    logic [TW-1:0] tmr;
    logic          rise;
    logic          fall;
    logic          en;

    assign rise   = i_fval & ~fval_d;
    assign fall   = ~i_fval & fval_d;
    assign en     = i_acquisition_start & i_stream_enable & i_encrypt_state;
    assign o_busy = state != IDLE;

    // fval_d resets high so a frame already running at reset release never looks like a rise
    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) begin
            state        <= IDLE;
            fval_d       <= 1'b1;
            abort        <= 1'b0;
            tmr          <= '0;
            o_fifo_reset <= 1'b0;
            o_fval       <= 1'b0;
            o_data_valid <= 1'b0;
            ov_data      <= '0;
            ov_frame_cnt <= '0;
        end else begin
            fval_d       <= i_fval;
            o_data_valid <= 1'b0;
            case (state)
                IDLE: if (rise) begin
                    tmr          <= '0;
                    abort        <= 1'b0;
                    state        <= en ? RST : DROP;
                    o_fifo_reset <= en;
                end
                RST: begin
                    tmr <= tmr + 1'b1;
                    if (fall) abort <= 1'b1;
                    if (tmr == TW'(RST_PULSE_LEN - 1)) begin
                        tmr          <= '0;
                        o_fifo_reset <= 1'b0;
                        state        <= (abort | fall) ? IDLE : GUARD;
                    end
                end
                GUARD: begin
                    tmr <= tmr + 1'b1;
                    if (fall) state <= IDLE;
                    else if (tmr == TW'(GUARD_CYCLES - 1)) begin
                        state  <= PASS;
                        o_fval <= 1'b1;
                    end
                end
                PASS: if (fall) begin
                    state        <= IDLE;
                    o_fval       <= 1'b0;
                    ov_frame_cnt <= ov_frame_cnt + 1'b1;
                end else begin
                    o_data_valid <= i_data_valid;
                    ov_data      <= iv_data;
                end
                DROP: if (fall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_FIX_CTRL_DROP_CNT_EN
    // an aborted frame counts once even if i_fval toggles again before the pulse ends
    logic drop_evt;
    assign drop_evt = (state == IDLE  & rise & ~en) |
                      (state == RST   & fall & ~abort) |
                      (state == GUARD & fall);

    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) ov_drop_cnt <= '0;
        else if (drop_evt && !(&ov_drop_cnt)) ov_drop_cnt <= ov_drop_cnt + 1'b1;
    end
`else
    assign ov_drop_cnt = '0;
`endif
endmodule
